// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: one trial subtraction per CALC cycle,
// WIDTH iterations per operation, results held until the next completed op.
module seq_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // start is only honoured outside CALC, so a busy divider never resamples.
  assign accept    = start && (state != CALC);
  assign last_iter = (count == CW'(WIDTH - 1));

  assign shifted = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {1'b0, d_reg};
  assign borrow  = trial[WIDTH];
  assign r_next  = borrow ? shifted : trial[WIDTH-1:0];
  assign q_next  = {q_work[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        state_next = last_iter ? DONE : CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == CALC);
    done      = (state == DONE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_reg       <= '0;
      q_work      <= '0;
      r_work      <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg       <= divisor;
      q_work      <= dividend;
      r_work      <= '0;
      count       <= '0;
      div_by_zero <= (divisor == '0);
      // Divide by zero skips CALC and publishes its fixed result immediately.
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      q_work <= q_next;
      r_work <= r_next;
      count  <= count + 1'b1;
      if (last_iter) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed and exhaustive bench for seq_div (WIDTH=4): expected results are
// queued at start and compared when done pulses.
module tb_seq_div;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   fsm_state;

  int total = 0;
  int bad   = 0;

  // Packed expectation: {quotient, remainder, div_by_zero}
  logic [2*W:0] exp_q[$];

  seq_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .fsm_state  (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, (b == 0)};
  endfunction

  // Called at a negedge; returns just after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom_range(0, 15));
    divisor  = W'($urandom_range(0, 15));
  endtask

  // Counts negedges until done; returns at the done negedge.
  task automatic wait_done(input int lat_exp, input string tag, output int busy_n);
    int cyc;
    bit seen;
    logic [2*W:0] e;
    cyc    = 0;
    seen   = 0;
    busy_n = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) chk({tag, " latency"}, 32'(cyc), 32'(lat_exp));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, " quotient"},  32'(quotient),    32'(e[2*W:W+1]));
      chk({tag, " remainder"}, 32'(remainder),   32'(e[W:1]));
      chk({tag, " dbz"},       32'(div_by_zero), 32'(e[0]));
    end
  endtask

  initial begin
    int bn;
    int done_cnt;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset q", 32'(quotient), 32'd0);
    chk("reset r", 32'(remainder), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    chk("reset state", 32'(fsm_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) basic 13/3 from IDLE
    start_op(4'd13, 4'd3);
    wait_done(5, "13/3", bn);
    chk("13/3 busy_cycles", 32'(bn), 32'd4);
    @(negedge clk);
    chk("13/3 done_pulse_width", 32'(done), 32'd0);

    // 2) directed corners
    start_op(4'd15, 4'd1);  wait_done(5, "15/1", bn);
    start_op(4'd7, 4'd9);   wait_done(5, "7/9", bn);
    start_op(4'd0, 4'd5);   wait_done(5, "0/5", bn);
    start_op(4'd15, 4'd15); wait_done(5, "15/15", bn);

    // 3) divide by zero, then a back-to-back op with held-result checks
    start_op(4'd9, 4'd0);
    wait_done(1, "9/0", bn);
    start_op(4'd8, 4'd2);
    @(negedge clk);
    chk("b2b done_drop", 32'(done), 32'd0);
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b held_q", 32'(quotient), 32'd15);
    chk("b2b held_r", 32'(remainder), 32'd9);
    chk("b2b dbz_cleared", 32'(div_by_zero), 32'd0);
    wait_done(4, "8/2", bn);
    @(negedge clk);

    // 4) start re-pulsed during CALC is ignored
    start_op(4'd13, 4'd3);
    @(negedge clk);
    dividend = 4'd2;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4, "ignore_start", bn);
    @(negedge clk);

    // 5) reset in the second CALC cycle aborts the op
    start_op(4'd10, 4'd3);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort state", 32'(fsm_state), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort q", 32'(quotient), 32'd0);
    chk("abort r", 32'(remainder), 32'd0);
    chk("abort dbz", 32'(div_by_zero), 32'd0);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort no_done", 32'(done_cnt), 32'd0);
    start_op(4'd6, 4'd4);
    wait_done(5, "6/4", bn);

    // 6) exhaustive, each op started in the previous op's DONE cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(W'(a), W'(b));
        wait_done((b == 0) ? 1 : 5, $sformatf("ex %0d/%0d", a, b), bn);
      end
    end

    chk("queue empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
